// File: rtl/fileio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fileio_pkg
// Brief   : Shared encodings and widths for the FileIO command sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package fileio_pkg;

  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
  localparam int TM_DATA_W      = 29;
  localparam int IC_ADDR_W      = 12;
  localparam int EMU_VAL_W      = 5;

  typedef enum logic [2:0] {
    OP_LOAD_TM  = 3'd0,
    OP_LOAD_IC  = 3'd1,
    OP_LOAD_MEM = 3'd2,
    OP_LOAD_EMU = 3'd3,
    OP_RUN      = 3'd4,
    OP_DUMP     = 3'd5,
    OP_CLEAR_TM = 3'd6,
    OP_ILLEGAL  = 3'd7
  } op_e;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_LD_TM    = 4'd1;
  localparam logic [3:0] ST_LD_IC    = 4'd2;
  localparam logic [3:0] ST_LD_MEM   = 4'd3;
  localparam logic [3:0] ST_LD_EMU   = 4'd4;
  localparam logic [3:0] ST_RUN      = 4'd5;
  localparam logic [3:0] ST_DUMP_RD  = 4'd6;
  localparam logic [3:0] ST_DUMP_OUT = 4'd7;
  localparam logic [3:0] ST_CLEAR_TM = 4'd8;

endpackage
`default_nettype wire

// File: rtl/fileio_if.sv
`default_nettype none
// ============================================================================
// Module  : fileio_if
// Brief   : Host-side command, data-in and dump-out handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface fileio_if;
  import fileio_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [15:0]       cmd_base;
  logic [15:0]       cmd_count;
  logic              din_valid;
  logic              din_ready;
  logic [WORD_W-1:0] din;
  logic              dout_valid;
  logic              dout_ready;
  logic [WORD_W-1:0] dout;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_count, din_valid, din, dout_ready,
    input  cmd_ready, din_ready, dout_valid, dout
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_count, din_valid, din, dout_ready,
    output cmd_ready, din_ready, dout_valid, dout
  );

endinterface
`default_nettype wire

// File: rtl/fileio_line_buf.sv
`default_nettype none
// ============================================================================
// Module  : fileio_line_buf
// Brief   : 256-bit line buffer, word shift-in/shift-out with a word counter.
// Revision: 1.0 - initial release
// ============================================================================
module fileio_line_buf
  import fileio_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_shift_in,
  input  logic [LINE_W-1:0] i_load_data,
  output logic [LINE_W-1:0] o_line,
  output logic              o_last_word
);

  logic [LINE_W-1:0] r_line;
  logic [2:0]        r_cnt;

  // Shifting moves toward the MSB so the first word lands in [255:224].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= '0;
      r_cnt  <= 3'd0;
    end else if (i_load) begin
      r_line <= i_load_data;
      r_cnt  <= 3'd0;
    end else if (i_shift) begin
      r_line <= {r_line[LINE_W-WORD_W-1:0], i_shift_in};
      r_cnt  <= r_cnt + 3'd1;
    end else if (i_clr) begin
      r_cnt  <= 3'd0;
    end
  end

  assign o_line      = r_line;
  assign o_last_word = (r_cnt == 3'(WORDS_PER_LINE - 1));

endmodule
`default_nettype wire

// File: rtl/fileio_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fileio_ctrl
// Brief   : Command-driven FileIO sequencer: loads TM/ICache/MEM/EMU, runs, dumps.
// Revision: 1.0 - initial release
// ============================================================================
module fileio_ctrl
  import fileio_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int SHMEM_DEPTH = 256,
  parameter int ADDR_W      = $clog2(MEM_DEPTH + SHMEM_DEPTH),
  parameter int EMU_ADDR_W  = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  fileio_if.slave               host,
  output logic                  busy,
  output logic                  err,
  output logic [31:0]           run_cycles,
  output logic                  Write_Enable_FIO_TM,
  output logic [TM_DATA_W-1:0]  Write_Data_FIO_TM,
  output logic                  start_FIO_TM,
  output logic                  clear_FIO_TM,
  input  logic                  finished_TM_FIO,
  output logic                  FileIO_Wen_ICache,
  output logic [IC_ADDR_W-1:0]  FileIO_Addr_ICache,
  output logic [WORD_W-1:0]     FileIO_Din_ICache,
  output logic                  FIO_MEMWRITE,
  output logic [ADDR_W-1:0]     FIO_ADDR,
  output logic [LINE_W-1:0]     FIO_WRITE_DATA,
  input  logic [LINE_W-1:0]     FIO_READ_DATA,
  output logic                  FIO_CACHE_LAT_WRITE,
  output logic [EMU_VAL_W-1:0]  FIO_CACHE_LAT_VALUE,
  output logic [EMU_ADDR_W-1:0] FIO_CACHE_MEM_ADDR
);

  logic [3:0]        r_state;
  logic [15:0]       r_base;
  logic [15:0]       r_count;
  logic [15:0]       r_idx;
  logic              r_rd_wait;

  logic              w_idle;
  logic              w_load_state;
  logic              w_din_acc;
  logic              w_dout_acc;
  logic              w_last_entry;
  logic [15:0]       w_cur_addr;
  logic [15:0]       w_next_addr;
  logic              w_lb_shift;
  logic              w_lb_load;
  logic [WORD_W-1:0] w_lb_in;
  logic [LINE_W-1:0] w_lb_line;
  logic              w_lb_last;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_load_state = (r_state == ST_LD_TM) || (r_state == ST_LD_IC) ||
                        (r_state == ST_LD_MEM) || (r_state == ST_LD_EMU);
  assign busy         = !w_idle;

  assign host.cmd_ready  = w_idle;
  assign host.din_ready  = w_load_state && (r_count != 16'd0);
  assign host.dout_valid = (r_state == ST_DUMP_OUT);
  assign host.dout       = w_lb_line[LINE_W-1 -: WORD_W];

  assign w_din_acc    = host.din_valid && host.din_ready;
  assign w_dout_acc   = host.dout_valid && host.dout_ready;
  assign w_last_entry = (r_idx == r_count - 16'd1);
  assign w_cur_addr   = r_base + r_idx;
  assign w_next_addr  = r_base + r_idx + 16'd1;

  assign w_lb_shift = ((r_state == ST_LD_MEM) && w_din_acc) || w_dout_acc;
  assign w_lb_load  = (r_state == ST_DUMP_RD) && r_rd_wait;
  assign w_lb_in    = (r_state == ST_LD_MEM) ? host.din : '0;

  fileio_line_buf u_line_buf (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_idle),
    .i_shift     (w_lb_shift),
    .i_load      (w_lb_load),
    .i_shift_in  (w_lb_in),
    .i_load_data (FIO_READ_DATA),
    .o_line      (w_lb_line),
    .o_last_word (w_lb_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state             <= ST_IDLE;
      r_base              <= 16'd0;
      r_count             <= 16'd0;
      r_idx               <= 16'd0;
      r_rd_wait           <= 1'b0;
      err                 <= 1'b0;
      run_cycles          <= 32'd0;
      Write_Enable_FIO_TM <= 1'b0;
      Write_Data_FIO_TM   <= '0;
      start_FIO_TM        <= 1'b0;
      clear_FIO_TM        <= 1'b0;
      FileIO_Wen_ICache   <= 1'b0;
      FileIO_Addr_ICache  <= '0;
      FileIO_Din_ICache   <= '0;
      FIO_MEMWRITE        <= 1'b0;
      FIO_ADDR            <= '0;
      FIO_WRITE_DATA      <= '0;
      FIO_CACHE_LAT_WRITE <= 1'b0;
      FIO_CACHE_LAT_VALUE <= '0;
      FIO_CACHE_MEM_ADDR  <= '0;
    end else begin
      Write_Enable_FIO_TM <= 1'b0;
      FileIO_Wen_ICache   <= 1'b0;
      FIO_MEMWRITE        <= 1'b0;
      FIO_CACHE_LAT_WRITE <= 1'b0;
      clear_FIO_TM        <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (host.cmd_valid) begin
            r_base    <= host.cmd_base;
            r_count   <= host.cmd_count;
            r_idx     <= 16'd0;
            r_rd_wait <= 1'b0;
            err       <= (op_e'(host.cmd_op) == OP_ILLEGAL);
            case (op_e'(host.cmd_op))
              OP_LOAD_TM:  r_state <= ST_LD_TM;
              OP_LOAD_IC:  r_state <= ST_LD_IC;
              OP_LOAD_MEM: r_state <= ST_LD_MEM;
              OP_LOAD_EMU: r_state <= ST_LD_EMU;
              OP_RUN: begin
                start_FIO_TM <= 1'b1;
                run_cycles   <= 32'd0;
                r_state      <= ST_RUN;
              end
              OP_DUMP: begin
                FIO_ADDR <= ADDR_W'(host.cmd_base);
                r_state  <= ST_DUMP_RD;
              end
              OP_CLEAR_TM: begin
                clear_FIO_TM <= 1'b1;
                r_state      <= ST_CLEAR_TM;
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end

        ST_LD_TM, ST_LD_IC, ST_LD_EMU, ST_LD_MEM: begin
          if (r_count == 16'd0) begin
            r_state <= ST_IDLE;
          end else if (w_din_acc) begin
            case (r_state)
              ST_LD_TM: begin
                Write_Enable_FIO_TM <= 1'b1;
                Write_Data_FIO_TM   <= host.din[TM_DATA_W-1:0];
              end
              ST_LD_IC: begin
                FileIO_Wen_ICache  <= 1'b1;
                FileIO_Addr_ICache <= IC_ADDR_W'(w_cur_addr);
                FileIO_Din_ICache  <= host.din;
              end
              ST_LD_EMU: begin
                FIO_CACHE_LAT_WRITE <= 1'b1;
                FIO_CACHE_MEM_ADDR  <= EMU_ADDR_W'(w_cur_addr);
                FIO_CACHE_LAT_VALUE <= host.din[EMU_VAL_W-1:0];
              end
              default: begin
                if (w_lb_last) begin
                  FIO_MEMWRITE   <= 1'b1;
                  FIO_ADDR       <= ADDR_W'(w_cur_addr);
                  FIO_WRITE_DATA <= {w_lb_line[LINE_W-WORD_W-1:0], host.din};
                end
              end
            endcase
            // MEM counts lines, the other loads count words.
            if ((r_state != ST_LD_MEM) || w_lb_last) begin
              r_idx <= r_idx + 16'd1;
              if (w_last_entry) begin
                r_state <= ST_IDLE;
              end
            end
          end
        end

        ST_RUN: begin
          if (run_cycles != 32'hFFFF_FFFF) begin
            run_cycles <= run_cycles + 32'd1;
          end
          if (finished_TM_FIO) begin
            start_FIO_TM <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end

        ST_DUMP_RD: begin
          if (r_count == 16'd0) begin
            r_state <= ST_IDLE;
          end else if (!r_rd_wait) begin
            r_rd_wait <= 1'b1;
          end else begin
            r_rd_wait <= 1'b0;
            r_state   <= ST_DUMP_OUT;
          end
        end

        ST_DUMP_OUT: begin
          if (w_dout_acc && w_lb_last) begin
            if (w_last_entry) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx    <= r_idx + 16'd1;
              FIO_ADDR <= ADDR_W'(w_next_addr);
              r_state  <= ST_DUMP_RD;
            end
          end
        end

        ST_CLEAR_TM: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fileio_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fileio_ctrl
// Brief   : Directed self-checking bench for fileio_ctrl with a scoreboard model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fileio_ctrl;
  import fileio_pkg::*;

  localparam int ADDR_W     = 9;
  localparam int EMU_ADDR_W = 8;

  bit clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  logic                  rst;
  fileio_if              h();
  logic                  busy, err;
  logic [31:0]           run_cycles;
  logic                  Write_Enable_FIO_TM;
  logic [TM_DATA_W-1:0]  Write_Data_FIO_TM;
  logic                  start_FIO_TM, clear_FIO_TM;
  logic                  finished_TM_FIO;
  logic                  FileIO_Wen_ICache;
  logic [IC_ADDR_W-1:0]  FileIO_Addr_ICache;
  logic [31:0]           FileIO_Din_ICache;
  logic                  FIO_MEMWRITE;
  logic [ADDR_W-1:0]     FIO_ADDR;
  logic [255:0]          FIO_WRITE_DATA;
  logic [255:0]          rd_data;
  logic                  FIO_CACHE_LAT_WRITE;
  logic [EMU_VAL_W-1:0]  FIO_CACHE_LAT_VALUE;
  logic [EMU_ADDR_W-1:0] FIO_CACHE_MEM_ADDR;

  fileio_ctrl #(.MEM_DEPTH(256), .SHMEM_DEPTH(256)) dut (
    .clk(clk_tb), .rst(rst), .host(h), .busy(busy), .err(err), .run_cycles(run_cycles),
    .Write_Enable_FIO_TM(Write_Enable_FIO_TM), .Write_Data_FIO_TM(Write_Data_FIO_TM),
    .start_FIO_TM(start_FIO_TM), .clear_FIO_TM(clear_FIO_TM), .finished_TM_FIO(finished_TM_FIO),
    .FileIO_Wen_ICache(FileIO_Wen_ICache), .FileIO_Addr_ICache(FileIO_Addr_ICache),
    .FileIO_Din_ICache(FileIO_Din_ICache), .FIO_MEMWRITE(FIO_MEMWRITE), .FIO_ADDR(FIO_ADDR),
    .FIO_WRITE_DATA(FIO_WRITE_DATA), .FIO_READ_DATA(rd_data),
    .FIO_CACHE_LAT_WRITE(FIO_CACHE_LAT_WRITE), .FIO_CACHE_LAT_VALUE(FIO_CACHE_LAT_VALUE),
    .FIO_CACHE_MEM_ADDR(FIO_CACHE_MEM_ADDR)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench-side content of never-written memory lines.
  function automatic logic [255:0] pattern(input int a);
    logic [255:0] l;
    for (int j = 0; j < 8; j++) l[255-32*j -: 32] = {8'hD0 + 8'(j), 8'h00, 16'(a)};
    return l;
  endfunction

  logic [255:0] ram    [512];
  bit           ram_wr [512];
  always @(posedge clk_tb) begin
    if (FIO_MEMWRITE) begin
      ram[FIO_ADDR]    <= FIO_WRITE_DATA;
      ram_wr[FIO_ADDR] <= 1'b1;
    end
    rd_data <= ram_wr[FIO_ADDR] ? ram[FIO_ADDR] : pattern(int'(FIO_ADDR));
  end

  logic [255:0] mdl   [512];
  bit           mdl_v [512];
  function automatic logic [255:0] exp_line(input int a);
    return mdl_v[a] ? mdl[a] : pattern(a);
  endfunction

  logic [31:0]  q_tm[$];
  logic [11:0]  q_ic_a[$];
  logic [31:0]  q_ic_d[$];
  logic [8:0]   q_mem_a[$];
  logic [255:0] q_mem_d[$];
  logic [7:0]   q_emu_a[$];
  logic [4:0]   q_emu_v[$];
  logic [31:0]  q_dout[$];

  bit          mon_en = 1'b0;
  int          start_seen = 0;
  int          clear_seen = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_dout;

  always @(negedge clk_tb) begin
    if (mon_en) begin
      if (Write_Enable_FIO_TM) begin
        if (q_tm.size() == 0) chk("tm_unexpected", Write_Enable_FIO_TM, 1'b0);
        else chk("tm_data", Write_Data_FIO_TM, q_tm.pop_front());
      end
      if (FileIO_Wen_ICache) begin
        if (q_ic_a.size() == 0) chk("ic_unexpected", FileIO_Wen_ICache, 1'b0);
        else begin
          chk("ic_addr", FileIO_Addr_ICache, q_ic_a.pop_front());
          chk("ic_data", FileIO_Din_ICache, q_ic_d.pop_front());
        end
      end
      if (FIO_MEMWRITE) begin
        if (q_mem_a.size() == 0) chk("mem_unexpected", FIO_MEMWRITE, 1'b0);
        else begin
          chk("mem_addr", FIO_ADDR, q_mem_a.pop_front());
          chk("mem_data", FIO_WRITE_DATA, q_mem_d.pop_front());
        end
      end
      if (FIO_CACHE_LAT_WRITE) begin
        if (q_emu_a.size() == 0) chk("emu_unexpected", FIO_CACHE_LAT_WRITE, 1'b0);
        else begin
          chk("emu_addr", FIO_CACHE_MEM_ADDR, q_emu_a.pop_front());
          chk("emu_val", FIO_CACHE_LAT_VALUE, q_emu_v.pop_front());
        end
      end
      if (prev_stall) begin
        chk("dout_hold_valid", h.dout_valid, 1'b1);
        chk("dout_hold_data", h.dout, prev_dout);
      end
      if (h.dout_valid && h.dout_ready) begin
        if (q_dout.size() == 0) chk("dout_unexpected", h.dout_valid, 1'b0);
        else chk("dout_word", h.dout, q_dout.pop_front());
      end
      if (!busy) begin
        chk("idle_cmd_ready", h.cmd_ready, 1'b1);
        chk("idle_din_ready", h.din_ready, 1'b0);
      end
      if (start_FIO_TM) start_seen++;
      if (clear_FIO_TM) clear_seen++;
      prev_stall = h.dout_valid && !h.dout_ready;
      prev_dout  = h.dout;
    end
  end

  bit tog = 1'b0;
  bit toggle_en = 1'b0;
  always @(posedge clk_tb) begin
    #1;
    tog = ~tog;
    h.dout_ready = toggle_en ? tog : 1'b1;
  end

  // All drivers below are entered and left at posedge+1.
  task automatic send_cmd(input logic [2:0] op, input logic [15:0] base, input logic [15:0] cnt);
    int t = 0;
    h.cmd_valid = 1'b1; h.cmd_op = op; h.cmd_base = base; h.cmd_count = cnt;
    @(negedge clk_tb);
    while (!h.cmd_ready && t < 500) begin @(negedge clk_tb); t++; end
    chk("cmd_accept", h.cmd_ready, 1'b1);
    @(posedge clk_tb); #1;
    h.cmd_valid = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] ws[$]);
    int t;
    foreach (ws[i]) begin
      h.din_valid = 1'b1; h.din = ws[i]; t = 0;
      @(negedge clk_tb);
      while (!h.din_ready && t < 500) begin @(negedge clk_tb); t++; end
      if (!h.din_ready) begin
        chk("din_accept", h.din_ready, 1'b1);
        break;
      end
      @(posedge clk_tb); #1;
    end
    h.din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk_tb);
    while (busy && t < 2000) begin @(negedge clk_tb); t++; end
    chk({name, "_idle"}, busy, 1'b0);
    repeat (2) @(posedge clk_tb);
    #1;
  endtask

  task automatic model_load_mem(input int base, input logic [31:0] ws[$]);
    logic [255:0] l;
    for (int k = 0; k < ws.size() / 8; k++) begin
      for (int j = 0; j < 8; j++) l[255-32*j -: 32] = ws[8*k+j];
      q_mem_a.push_back(9'(base + k));
      q_mem_d.push_back(l);
      mdl[(base + k) % 512]   = l;
      mdl_v[(base + k) % 512] = 1'b1;
    end
  endtask

  task automatic do_dump(input int base, input int cnt);
    logic [255:0] l;
    for (int k = 0; k < cnt; k++) begin
      l = exp_line((base + k) % 512);
      for (int j = 0; j < 8; j++) q_dout.push_back(l[255-32*j -: 32]);
    end
    toggle_en = 1'b1;
    send_cmd(3'(OP_DUMP), 16'(base), 16'(cnt));
    wait_idle("dump");
    toggle_en = 1'b0;
    chk("dump_words_left", 32'(q_dout.size()), 32'd0);
  endtask

  logic [31:0] ws[$];

  initial begin
    rst = 1'b0; finished_TM_FIO = 1'b0;
    h.cmd_valid = 1'b0; h.cmd_op = 3'd0; h.cmd_base = 16'd0; h.cmd_count = 16'd0;
    h.din_valid = 1'b0; h.din = 32'd0;
    repeat (3) @(posedge clk_tb);
    @(negedge clk_tb);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_run_cycles", run_cycles, 32'd0);
    chk("rst_start", start_FIO_TM, 1'b0);
    chk("rst_addr", FIO_ADDR, 9'd0);
    chk("rst_din_ready", h.din_ready, 1'b0);
    chk("rst_dout_valid", h.dout_valid, 1'b0);
    @(posedge clk_tb); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_tb); #1;

    // ICache load crossing 0x3FF -> 0x400, literal expectations.
    q_ic_a = '{12'h3FE, 12'h3FF, 12'h400};
    q_ic_d = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    send_cmd(3'(OP_LOAD_IC), 16'h03FE, 16'd3);
    send_words('{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003});
    wait_idle("ld_ic");
    chk("ic_left", 32'(q_ic_a.size()), 32'd0);

    // TM load keeps the low 29 bits.
    ws = '{32'hFFFF_FFFF, 32'h1234_5678};
    foreach (ws[i]) q_tm.push_back(ws[i] & 32'h1FFF_FFFF);
    send_cmd(3'(OP_LOAD_TM), 16'd0, 16'd2);
    send_words(ws);
    wait_idle("ld_tm");
    chk("tm_left", 32'(q_tm.size()), 32'd0);

    // EMU load wrapping at the 8-bit address width.
    ws = '{32'h0000_0013, 32'hFFFF_FFE7, 32'h0000_0021};
    foreach (ws[i]) begin
      q_emu_a.push_back(8'((16'h00FE + i) % 256));
      q_emu_v.push_back(ws[i][4:0]);
    end
    send_cmd(3'(OP_LOAD_EMU), 16'h00FE, 16'd3);
    send_words(ws);
    wait_idle("ld_emu");
    chk("emu_left", 32'(q_emu_a.size()), 32'd0);

    // Two MEM lines, literal line images.
    ws = {};
    for (int i = 0; i < 16; i++) ws.push_back(32'(i));
    q_mem_a.push_back(9'd5);
    q_mem_d.push_back(256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007);
    q_mem_a.push_back(9'd6);
    q_mem_d.push_back(256'h00000008_00000009_0000000A_0000000B_0000000C_0000000D_0000000E_0000000F);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) mdl[5+k][255-32*j -: 32] = 32'(8*k + j);
      mdl_v[5+k] = 1'b1;
    end
    send_cmd(3'(OP_LOAD_MEM), 16'd5, 16'd2);
    send_words(ws);
    wait_idle("ld_mem");
    chk("mem_left", 32'(q_mem_a.size()), 32'd0);

    // Dumps with dout_ready toggling.
    do_dump(1, 2);
    do_dump(5, 2);

    // RUN: finished arrives in the 100th running cycle.
    start_seen = 0;
    send_cmd(3'(OP_RUN), 16'd0, 16'd0);
    repeat (99) @(posedge clk_tb);
    #1 finished_TM_FIO = 1'b1;
    @(posedge clk_tb); #1 finished_TM_FIO = 1'b0;
    wait_idle("run");
    chk("run_cycles_100", run_cycles, 32'd100);
    chk("run_start_cycles", 32'(start_seen), 32'd100);
    chk("run_start_low", start_FIO_TM, 1'b0);

    // RUN with finished already high.
    start_seen = 0;
    finished_TM_FIO = 1'b1;
    send_cmd(3'(OP_RUN), 16'd0, 16'd0);
    wait_idle("run_fast");
    finished_TM_FIO = 1'b0;
    chk("run_cycles_1", run_cycles, 32'd1);
    chk("run_fast_start", 32'(start_seen), 32'd1);

    clear_seen = 0;
    send_cmd(3'(OP_CLEAR_TM), 16'd0, 16'd0);
    wait_idle("clear");
    chk("clear_cycles", 32'(clear_seen), 32'd1);

    // Illegal op, then an empty TM load clears err.
    send_cmd(3'(OP_ILLEGAL), 16'd0, 16'd0);
    @(negedge clk_tb);
    chk("err_set", err, 1'b1);
    chk("err_busy", busy, 1'b0);
    @(posedge clk_tb); #1;
    send_cmd(3'(OP_LOAD_TM), 16'd0, 16'd0);
    wait_idle("ld_tm0");
    chk("err_cleared", err, 1'b0);

    // Reset mid-line discards the partial line.
    send_cmd(3'(OP_LOAD_MEM), 16'd9, 16'd1);
    send_words('{32'h11, 32'h22, 32'h33, 32'h44, 32'h55});
    rst = 1'b0;
    @(negedge clk_tb);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", FIO_ADDR, 9'd0);
    chk("mid_rst_memwrite", FIO_MEMWRITE, 1'b0);
    @(posedge clk_tb); #1 rst = 1'b1;
    @(posedge clk_tb); #1;
    ws = {};
    for (int i = 0; i < 8; i++) ws.push_back(32'h100 + 32'(i));
    model_load_mem(9, ws);
    send_cmd(3'(OP_LOAD_MEM), 16'd9, 16'd1);
    send_words(ws);
    wait_idle("ld_mem_fresh");
    chk("mem_fresh_left", 32'(q_mem_a.size()), 32'd0);
    do_dump(9, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fileio_ctrl.md
Name: fileio_ctrl

Overview:
- Hardware sequencer for the FileIO side of gpu_top_checking. Replaces bench-driven preload, run and dump with one command-driven FSM.
- A host issues commands and streams 32-bit words in. The block writes the task manager (TM), instruction cache (ICache), data memory (MEM) and cache-latency emulation table (EMU), launches execution and times it.
- It streams MEM contents back out on a 32-bit data port.
- Sits between the host link (UART/PCIe bridge) and gpu_top_checking's FIO ports.

Parameters:
- MEM_DEPTH, 256, global memory lines.
- SHMEM_DEPTH, 256, shared memory lines.
- ADDR_W, $clog2(MEM_DEPTH+SHMEM_DEPTH), MEM line address width.
- EMU_ADDR_W, $clog2(MEM_DEPTH), EMU table address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_op  in  3  0 LOAD_TM, 1 LOAD_IC, 2 LOAD_MEM, 3 LOAD_EMU, 4 RUN, 5 DUMP, 6 CLEAR_TM, 7 illegal.
- cmd_base  in  16  start address.
- cmd_count  in  16  entries (MEM: 256-bit lines).
- din_valid  in  1  host data word valid.
- din_ready  out  1  host data word accepted.
- din  in  32  host data word.
- dout_valid  out  1  dump word valid.
- dout_ready  in  1  host accepts dump word.
- dout  out  32  dump word.
- busy  out  1  high whenever not IDLE.
- err  out  1  sticky illegal-op flag.
- run_cycles  out  32  cycles of last RUN.
- Write_Enable_FIO_TM  out  1  TM write strobe.
- Write_Data_FIO_TM  out  29  TM write data.
- start_FIO_TM  out  1  TM start.
- clear_FIO_TM  out  1  TM clear.
- finished_TM_FIO  in  1  TM finished.
- FileIO_Wen_ICache  out  1  ICache write enable.
- FileIO_Addr_ICache  out  12  ICache address.
- FileIO_Din_ICache  out  32  ICache write data.
- FIO_MEMWRITE  out  1  MEM write enable.
- FIO_ADDR  out  ADDR_W  MEM address.
- FIO_WRITE_DATA  out  256  MEM write data.
- FIO_READ_DATA  in  256  MEM read data.
- FIO_CACHE_LAT_WRITE  out  1  EMU write enable.
- FIO_CACHE_LAT_VALUE  out  5  EMU latency value.
- FIO_CACHE_MEM_ADDR  out  EMU_ADDR_W  EMU address.

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE.
  - All strobes, start_FIO_TM, clear_FIO_TM, dout_valid, din_ready, busy, err = 0.
  - All address and data outputs = 0; run_cycles = 0.
  - Reset mid-operation abandons the command; a partial MEM line is discarded.
- All FIO outputs are registered.
- States:
  - IDLE: cmd_ready=1. On accept, latch op, base and count into idx/addr counters, then go to the op state.
    - count=0 for load or dump ops: returns to IDLE next cycle with no strobes.
    - op 7: sets err, stays IDLE.
    - Any other accepted command clears err.
  - LD_TM / LD_IC / LD_EMU: din_ready=1.
    - Each accepted word produces a one-cycle write strobe the next cycle.
    - TM data = din[28:0]. ICache addr = base+idx, data = din. EMU addr = base+idx, value = din[4:0].
    - Addresses truncate (wrap) to port width.
    - After count words, go to IDLE.
  - LD_MEM: accepted words shift into a 256-bit line, first word into [255:224], 8th into [31:0].
    - On the 8th word, FIO_MEMWRITE pulses one cycle with addr = base+line.
    - din_ready is also high in that cycle; the next word begins the next line.
  - CLEAR_TM: clear_FIO_TM=1 for exactly one cycle, then IDLE.
  - RUN:
    - start_FIO_TM=1 and run_cycles reset to 0 on entry.
    - run_cycles increments each cycle while running and saturates at 0xFFFFFFFF.
    - On finished_TM_FIO=1: start drops the next cycle, run_cycles freezes, FSM goes to IDLE.
    - finished already high on entry: completes in 1 cycle with run_cycles=1.
  - DUMP_RD: drive FIO_ADDR = base+line, wait 1 cycle for the synchronous read, capture FIO_READ_DATA.
  - DUMP_OUT: emit 8 words MSB first.
    - dout and dout_valid are held stable while dout_ready=0.
    - After the 8th handshake, the next line goes to DUMP_RD, otherwise IDLE.
- din is ignored and din_ready=0 outside load states.
- busy=1 in every non-IDLE state.

Decomposition:
- Package fileio_pkg: op encodings, state enum, WORDS_PER_LINE=8, TM_DATA_W=29, IC_ADDR_W=12, EMU_VAL_W=5.
- Sub-module fileio_line_buf: 256-bit shift-in/shift-out buffer with 3-bit word counter, shared by LD_MEM and DUMP.

Test Plan:
- LOAD_IC base=0x3FE count=3, words A,B,C -> three Wen pulses at addresses 0x3FE, 0x3FF, 0x400; data A,B,C.
- LOAD_MEM base=5 count=2, words 0..15 -> two FIO_MEMWRITE pulses.
  - addr5 line = 00000000_00000001_..._00000007.
  - addr6 line = 00000008_..._0000000F.
- RUN with finished asserted 100 cycles after start -> start_FIO_TM high for 100 cycles, then low; run_cycles=100; busy low after.
- DUMP base=1 count=2 with dout_ready toggling 1/0 -> 16 words MSB-first per line, no drop or duplicate, dout stable during stalls.
- cmd_op=7 -> err=1, no strobes. Next LOAD_TM count=0 -> err=0, no Write_Enable.
- rst low mid LOAD_MEM after 5 words -> no FIO_MEMWRITE. Fresh LOAD_MEM writes a correctly aligned line.
